// File: rtl/cnn_mac_pipe.sv
// Pipelined signed x unsigned multiply-accumulate with first/last framing.
// Optional build macro: CNN_MAC_SAT_EN (saturate the sum on overflow instead of wrapping).
module cnn_mac_pipe #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 7,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  first,
  input  logic                  last,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic                  out_valid,
  output logic                  ovf
);

  localparam int PW  = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam int AW1 = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [DIN0_WIDTH-1:0] a_q;
  logic [DIN1_WIDTH-1:0] b_q;
  logic                  v_q, f_q, l_q;

  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  p_pipe [NUM_STAGE];
  logic [NUM_STAGE-1:0]  v_pipe, f_pipe, l_pipe;

  logic signed [PW-1:0]        p_t;
  logic                        v_t, f_t, l_t;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        ovf_acc;
  logic signed [AW1-1:0]       base, sum_w;
  logic [ACC_WIDTH-1:0]        sum_res;
  logic                        ovf_now, ovf_run;

  // Operand capture register; the multiply happens between this and the product pipe.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
      f_q <= 1'b0;
      l_q <= 1'b0;
    end else if (ce) begin
      a_q <= din0;
      b_q <= din1;
      v_q <= in_valid;
      f_q <= first;
      l_q <= last;
    end
  end

  // Both operands are widened to the exact product width, so the product cannot truncate.
  assign prod = PW'($signed(a_q)) * PW'($signed({1'b0, b_q}));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_STAGE; i++) p_pipe[i] <= '0;
      v_pipe <= '0;
      f_pipe <= '0;
      l_pipe <= '0;
    end else if (ce) begin
      for (int i = NUM_STAGE - 1; i > 0; i--) begin
        p_pipe[i] <= p_pipe[i-1];
        v_pipe[i] <= v_pipe[i-1];
        f_pipe[i] <= f_pipe[i-1];
        l_pipe[i] <= l_pipe[i-1];
      end
      p_pipe[0] <= prod;
      v_pipe[0] <= v_q;
      f_pipe[0] <= f_q;
      l_pipe[0] <= l_q;
    end
  end

  assign p_t = p_pipe[NUM_STAGE-1];
  assign v_t = v_pipe[NUM_STAGE-1];
  assign f_t = f_pipe[NUM_STAGE-1];
  assign l_t = l_pipe[NUM_STAGE-1];

  // One guard bit above the accumulator exposes overflow as a mismatch of the top two bits.
  always_comb begin
    base    = f_t ? '0 : AW1'(acc);
    sum_w   = base + AW1'(p_t);
    ovf_now = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];
    ovf_run = (f_t ? 1'b0 : ovf_acc) | ovf_now;
`ifdef CNN_MAC_SAT_EN
    if (ovf_now) sum_res = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else         sum_res = sum_w[ACC_WIDTH-1:0];
`else
    sum_res = sum_w[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc       <= '0;
      ovf_acc   <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= 1'b0;
      if (v_t) begin
        if (l_t) begin
          dout      <= sum_res;
          ovf       <= ovf_run;
          out_valid <= 1'b1;
          acc       <= '0;
          ovf_acc   <= 1'b0;
        end else begin
          acc     <= sum_res;
          ovf_acc <= ovf_run;
        end
      end
    end
  end

endmodule
